// File: rtl/avg_frame_packer_if.sv
// avg_frame_packer_if
//   Bundles the sample-side and frame-side handshakes of avg_frame_packer.
//   master : producer/consumer view (drives samples, flush, frame_ready)
//   slave  : packer view (drives in_ready, operands a..h, sa, frame_valid,
//            frame_cnt, sum_out)
//   Signals:
//     in_data/in_valid/in_ready  serial sample handshake
//     flush                      close a partial frame early
//     a..h                       frame operands, slot 0 = a, slot 7 = h
//     sa                         constant shift amount
//     frame_valid/frame_ready    frame handshake
//     frame_cnt                  real samples in the frame (1..8)
//     sum_out                    frame sum (0 unless AVG_SUM_CHECK_EN)
interface avg_frame_packer_if #(
    parameter int DATAWIDTH = 16
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [DATAWIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]           sa;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [3:0]           frame_cnt;
    logic [DATAWIDTH+2:0] sum_out;

    modport master (
        output in_data, in_valid, flush, frame_ready,
        input  in_ready, a, b, c, d, e, f, g, h, sa, frame_valid, frame_cnt, sum_out
    );

    modport slave (
        input  in_data, in_valid, flush, frame_ready,
        output in_ready, a, b, c, d, e, f, g, h, sa, frame_valid, frame_cnt, sum_out
    );
endinterface

// File: rtl/avg_frame_packer.sv
// avg_frame_packer
//   Packs a serial stream of DATAWIDTH-bit samples into 8-operand frames
//   for the 8-input averaging datapath. A frame is presented on a..h with
//   the constant shift amount sa under a valid/ready handshake and held
//   stable until consumed. A partial frame can be closed early with flush;
//   unwritten slots are zero-padded.
//   Ports:
//     Clk  rising-edge clock
//     Rst  synchronous, active-low reset
//     bus  avg_frame_packer_if.slave (sample handshake, flush, frame outputs)
//   Optional feature:
//     AVG_SUM_CHECK_EN  when defined, a running accumulator produces sum_out
//                       (sum of the 8 slots); otherwise sum_out is tied to 0.
module avg_frame_packer #(
    parameter int DATAWIDTH = 16,
    parameter int SHAMT     = 1
) (
    input logic              Clk,
    input logic              Rst,
    avg_frame_packer_if.slave bus
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t               state;
    logic [DATAWIDTH-1:0] slot [8];
    logic [3:0]           cnt;
    logic [3:0]           cnt_next;
    logic [3:0]           frame_cnt_q;
    logic                 frame_valid_q;
    logic                 in_ready;
    logic                 in_xfer;
    logic                 enter_hold;

    // In HOLD, a sample is only accepted together with the outgoing frame,
    // so the new frame starts in slot a without a bubble cycle.
    always_comb begin
        in_ready   = Rst && ((state == FILL) || bus.frame_ready);
        in_xfer    = bus.in_valid && in_ready;
        cnt_next   = cnt + {3'b000, in_xfer};
        enter_hold = (state == FILL) &&
                     ((cnt_next == 4'd8) || (bus.flush && (cnt_next != 4'd0)));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state         <= FILL;
            cnt           <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                slot[3'(i)] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_xfer) begin
                        slot[cnt[2:0]] <= bus.in_data;
                    end
                    cnt <= cnt_next;
                    if (enter_hold) begin
                        state         <= HOLD;
                        frame_valid_q <= 1'b1;
                        frame_cnt_q   <= cnt_next;
                        // Early close: clear every slot past the last real sample
                        // (a sample landing this cycle sits below cnt_next).
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (4'(i) >= cnt_next) begin
                                slot[3'(i)] <= '0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.frame_ready) begin
                        state         <= FILL;
                        frame_valid_q <= 1'b0;
                        if (in_xfer) begin
                            slot[0] <= bus.in_data;
                            cnt     <= 4'd1;
                        end else begin
                            cnt     <= 4'd0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef AVG_SUM_CHECK_EN
    logic [DATAWIDTH+2:0] acc;
    logic [DATAWIDTH+2:0] acc_next;
    logic [DATAWIDTH+2:0] sum_q;

    always_comb begin
        acc_next = acc + (in_xfer ? {3'b000, bus.in_data} : '0);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            acc   <= '0;
            sum_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    acc <= acc_next;
                    if (enter_hold) begin
                        sum_q <= acc_next;
                    end
                end
                HOLD: begin
                    if (bus.frame_ready) begin
                        acc <= in_xfer ? {3'b000, bus.in_data} : '0;
                    end
                end
                default: acc <= '0;
            endcase
        end
    end

    assign bus.sum_out = sum_q;
`else
    assign bus.sum_out = '0;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.sa          = 8'(SHAMT);
    assign bus.a           = slot[0];
    assign bus.b           = slot[1];
    assign bus.c           = slot[2];
    assign bus.d           = slot[3];
    assign bus.e           = slot[4];
    assign bus.f           = slot[5];
    assign bus.g           = slot[6];
    assign bus.h           = slot[7];

endmodule

// File: tb/tb_avg_frame_packer.sv
// tb_avg_frame_packer
//   Directed-vector bench for avg_frame_packer. Expected frames are queued
//   when stimulus is issued; a monitor pops and compares on every frame
//   transfer. Expected sums follow AVG_SUM_CHECK_EN (0 when undefined).
module tb_avg_frame_packer;

    localparam int DW = 16;
`ifdef AVG_SUM_CHECK_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0][DW-1:0] op;
        logic [3:0]         cnt;
        logic [DW+2:0]      sum;
    } frame_t;

    logic   clk;
    logic   rst;
    frame_t expq[$];
    int     vectors;
    int     miscompares;

    avg_frame_packer_if #(.DATAWIDTH(DW)) bus ();

    avg_frame_packer #(.DATAWIDTH(DW), .SHAMT(1)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic frame_t mk(input logic [DW-1:0] v0, v1, v2, v3, v4, v5, v6, v7,
                                  input logic [3:0] cnt, input logic [DW+2:0] sum);
        frame_t fr;
        fr.op  = {v7, v6, v5, v4, v3, v2, v1, v0};
        fr.cnt = cnt;
        fr.sum = SUM_EN ? sum : '0;
        return fr;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
    endtask

    task automatic release_frame();
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        check("released_fv", bus.frame_valid, 0);
    endtask

    // Monitor: a frame transfer is visible at the negedge before the edge
    // that consumes it.
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.frame_valid && bus.frame_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got frame a=%0h cnt=%0d, required no frame",
                             bus.a, bus.frame_cnt);
                end else begin
                    e = expq.pop_front();
                    check("frame_a", bus.a, e.op[0]);
                    check("frame_b", bus.b, e.op[1]);
                    check("frame_c", bus.c, e.op[2]);
                    check("frame_d", bus.d, e.op[3]);
                    check("frame_e", bus.e, e.op[4]);
                    check("frame_f", bus.f, e.op[5]);
                    check("frame_g", bus.g, e.op[6]);
                    check("frame_h", bus.h, e.op[7]);
                    check("frame_cnt", bus.frame_cnt, e.cnt);
                    check("frame_sum", bus.sum_out, e.sum);
                    check("frame_sa", bus.sa, 1);
                end
            end
        end
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_data     = 16'h1234;
        bus.flush       = 1'b0;
        bus.frame_ready = 1'b0;

        // 1. Reset held 3 cycles with in_valid high
        repeat (3) step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_fv", bus.frame_valid, 0);
        check("rst_ops", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h}, 0);
        check("rst_sa", bus.sa, 1);
        check("rst_cnt", bus.frame_cnt, 0);
        check("rst_sum", bus.sum_out, 0);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_fv", bus.frame_valid, 0);

        // 2. Full frame 1..8, consumer stalled
        expq.push_back(mk(1, 2, 3, 4, 5, 6, 7, 8, 8, 36));
        for (int i = 1; i <= 8; i++) begin
            send(DW'(i));
            if (i == 7) check("fill_fv_low", bus.frame_valid, 0);
        end
        idle();
        check("full_fv_latency", bus.frame_valid, 1);
        check("hold_in_ready", bus.in_ready, 0);
        repeat (2) step();
        check("hold_stable_fv", bus.frame_valid, 1);
        check("hold_stable_h", bus.h, 8);
        release_frame();

        // 3. Back-to-back 0xFFFF x16 with consumer always ready
        expq.push_back(mk('1, '1, '1, '1, '1, '1, '1, '1, 8, 19'h7FFF8));
        expq.push_back(mk('1, '1, '1, '1, '1, '1, '1, '1, 8, 19'h7FFF8));
        bus.frame_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("b2b_in_ready", bus.in_ready, 1);
            send(16'hFFFF);
        end
        idle();
        step();
        // Same again with distinct values so slot placement is visible
        expq.push_back(mk(1, 2, 3, 4, 5, 6, 7, 8, 8, 36));
        expq.push_back(mk(9, 10, 11, 12, 13, 14, 15, 16, 8, 100));
        for (int i = 1; i <= 16; i++) begin
            check("b2b2_in_ready", bus.in_ready, 1);
            send(DW'(i));
        end
        idle();
        step();
        bus.frame_ready = 1'b0;
        check("b2b_drained_fv", bus.frame_valid, 0);

        // 4. Flush after 10,20,30; stale slots must be cleared
        expq.push_back(mk(10, 20, 30, 0, 0, 0, 0, 0, 3, 60));
        send(10); send(20); send(30);
        idle();
        check("pre_flush_fv", bus.frame_valid, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_fv", bus.frame_valid, 1);
        release_frame();
        bus.flush = 1'b1;
        repeat (2) step();
        bus.flush = 1'b0;
        check("flush_empty_fv", bus.frame_valid, 0);

        // 5. Flush coinciding with a sample of 40
        expq.push_back(mk(10, 20, 30, 40, 0, 0, 0, 0, 4, 100));
        send(10); send(20); send(30);
        bus.flush = 1'b1;
        send(40);
        idle();
        check("flush_in_fv", bus.frame_valid, 1);
        release_frame();

        // 6. Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) send(DW'(50 + i));
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_fv", bus.frame_valid, 0);
        check("midrst_a", bus.a, 0);
        expq.push_back(mk(100, 101, 102, 103, 104, 105, 106, 107, 8, 828));
        for (int i = 0; i < 8; i++) send(DW'(100 + i));
        idle();
        check("midrst_frame_fv", bus.frame_valid, 1);
        release_frame();

        repeat (3) step();
        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avg_frame_packer.md
Name: avg_frame_packer

Overview:
- Producer-side companion to the 8-input averaging datapath.
- Accepts a serial stream of 16-bit samples with a valid/ready handshake and packs them into 8-operand frames on ports a..h.
- Presents each frame with the constant shift amount sa under a frame valid/ready handshake, so the downstream adder tree, shifters and REG see a stable parallel operand set.
- Supports early flush of a partial frame, zero-padded.

Parameters:
- DATAWIDTH, 16, width of each sample and of each operand port a..h.
- SHAMT, 1, constant value driven on sa; 1 gives divide-by-8 through three cascaded shifters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-low reset.
- in_data  input  DATAWIDTH  incoming sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  packer can accept a sample this cycle.
- flush  input  1  close the current partial frame.
- a, b, c, d, e, f, g, h  output  DATAWIDTH each  frame operands; slot 0 is a, slot 7 is h.
- sa  output  8  shift amount, constant SHAMT.
- frame_valid  output  1  a..h hold a complete frame.
- frame_ready  input  1  downstream consumes the frame.
- frame_cnt  output  4  number of real samples in the frame, 1..8.
- sum_out  output  DATAWIDTH+3  frame sum (see Optional Feature).

Behaviour:
- Reset is synchronous, active-low: Rst==0 sampled at a Clk edge clears all state.
  - a..h = 0, frame_valid = 0, frame_cnt = 0, sum_out = 0, slot counter = 0, state = FILL.
  - in_ready = 0 while Rst==0; in_ready = 1 in the first cycle after release.
- Reset mid-frame or mid-HOLD discards the frame with no partial output. sa = SHAMT at all times, including reset.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when frame_valid && frame_ready.
  - Once asserted, frame_valid stays high and a..h, frame_cnt and sum_out stay stable until the transfer.
- States:
  - FILL: in_ready = 1, frame_valid = 0.
    - Each transfer writes in_data to slot[cnt] and increments cnt.
    - When the 8th sample lands (cnt 7 -> 8), go to HOLD at the next edge.
    - frame_valid = 1 in the cycle after the 8th transfer, so latency from the last sample to frame_valid is 1 cycle.
  - HOLD: frame_valid = 1; in_ready = frame_ready (pass-through).
    - On an output transfer with no simultaneous input: cnt = 0, go to FILL.
    - On an output transfer with a simultaneous input transfer: that sample goes to slot a of the new frame, cnt = 1, FILL. No bubble.
    - Slots not yet rewritten keep stale values and are not observable, since frame_valid = 0.
- Flush:
  - flush in FILL with cnt>0: unwritten slots are zero-filled, frame_cnt = cnt, HOLD next cycle.
  - If an input transfer coincides with flush, that sample is included first (frame_cnt = cnt+1).
  - flush with cnt==0 and no input: ignored.
  - flush in HOLD: ignored.
- Full frame: frame_cnt = 8.
- Arithmetic:
  - sum_out is the unsigned sum of the 8 slots; DATAWIDTH+3 bits, so no overflow.
  - The zero-padded slots contribute 0.

Optional Feature:
- Macro: AVG_SUM_CHECK_EN.
- Defined: a running accumulator is updated on each input transfer, cleared on frame start, and latched to sum_out when entering HOLD. Downstream uses it to cross-check the adder-tree result (sum_out >> 3*SHAMT equals avg).
- Undefined: no accumulator is built and sum_out is tied to 0.

Test Plan:
1. Reset: hold Rst=0 for 3 cycles with in_valid=1 -> in_ready=0, frame_valid=0, a..h=0, sa=1; release -> in_ready=1 the next cycle.
2. Full frame: samples 1..8 on consecutive cycles, frame_ready=0 -> frame_valid=1 one cycle after the 8th sample, a=1 ... h=8, frame_cnt=8, in_ready=0. With AVG_SUM_CHECK_EN defined, sum_out=36.
3. Back-to-back: frame_ready=1 and samples 0xFFFF x16 continuously -> two frames with no bubble, the 9th sample lands in a of frame 2. With AVG_SUM_CHECK_EN defined, sum_out=0x7FFF8 (fits 19 bits).
4. Flush: samples 10, 20, 30, then flush with no input -> a=10, b=20, c=30, d..h=0, frame_cnt=3. With AVG_SUM_CHECK_EN defined, sum_out=60. Flush with cnt=0 -> no frame.
5. Flush coinciding with an input of 40 after samples 10, 20, 30 -> frame_cnt=4, d=40.
6. Reset mid-frame: after 5 samples drive Rst=0 for one cycle, then 8 samples 100..107 -> the single frame a=100 ... h=107; no trace of the earlier samples.
